res_add_unit: RTL and testbench
===============================

// Module: res_add_unit
// PURPOSE
// - Residual-add stage directly upstream of the activation unit; produces the res2ac AXI-Stream.
// - Joins the partial-sum stream (ps2res) with a residual stream read from memory (rd2res).
// - Adds per int8 lane with saturation, or passes ps2res through when residual add is off.
// - Output is registered through a 2-entry skid buffer: full throughput, no comb in->out paths.
// PARAMETERS
// - AXI_DATA_WIDTH  `DFLT_CORE_AXI_DATA_WIDTH  stream width in bits; must be a multiple of 8
// PORTS
// - clk                   in   1      clock
// - rst_n                 in   1      reset, synchronous, active-low
// - cfg_res_en            in   1      1 = add residual this frame; sampled at frame start only
// - s_axis_ps2res_tready  out  1      partial-sum stream ready
// - s_axis_ps2res_tvalid  in   1      partial-sum stream valid
// - s_axis_ps2res_tdata   in   W      partial sums, W/8 signed int8 lanes
// - s_axis_ps2res_tkeep   in   W/8    byte enables
// - s_axis_ps2res_tlast   in   1      end of frame
// - s_axis_rd2res_tready  out  1      residual stream ready
// - s_axis_rd2res_tvalid  in   1      residual stream valid
// - s_axis_rd2res_tdata   in   W      residual values, W/8 signed int8 lanes
// - s_axis_rd2res_tlast   in   1      residual end of frame; checked only
// - m_axis_res2ac_tready  in   1      downstream ready
// - m_axis_res2ac_tvalid  out  1      output valid
// - m_axis_res2ac_tdata   out  W      result lanes
// - m_axis_res2ac_tkeep   out  W/8    forwarded from ps2res
// - m_axis_res2ac_tlast   out  1      forwarded from ps2res
// - err_last_mismatch     out  1      sticky: tlast disagreement in ADD mode
// - frame_active          out  1      1 while FSM is not IDLE
// BEHAVIOUR
// - Reset: FSM=IDLE, skid buffer empty. Every output is 0: all tready/tvalid/tdata/tkeep/tlast,
//   err_last_mismatch and frame_active. Reset mid-frame drops buffered and partial beats.
// - FSM states: IDLE, PASS, ADD. mode = (IDLE) ? cfg_res_en : (state==ADD).
// - space = buffer count < 2 (registered).
// - s_axis_ps2res_tready = space & (~mode | s_axis_rd2res_tvalid).
// - s_axis_rd2res_tready = space & mode & s_axis_ps2res_tvalid.
// - fire = ps2res tvalid & tready. When mode=1, both streams transfer in the same cycle.
// - On fire: tlast=1 -> IDLE; otherwise -> ADD if mode, else PASS.
//   IDLE with no fire stays IDLE. cfg_res_en changes mid-frame are ignored.
// - PASS fire: out lane = ps lane.
// - ADD fire: 9-bit signed sum; >127 -> 127, <-128 -> -128, else sum[7:0].
// - Lanes with tkeep=0 output 0x00. tkeep and tlast are copied from ps2res.
// - ADD fire with ps tlast != rd tlast: err_last_mismatch <= 1 and holds until reset.
//   The frame still ends on ps tlast.
// - Skid buffer: 2-entry FIFO; tvalid = count != 0.
//   Push and pop in the same cycle -> count unchanged.
//   Push only at count<2; pop only when m_axis_res2ac_tready.
// - Latency: a beat fired in cycle N is presented in cycle N+1 if the buffer was empty or popped
//   in cycle N. Sustained 1 beat/cycle when downstream ready is held high.
// - Output data, keep and last remain stable while tvalid=1 and tready=0.
// - frame_active = (state != IDLE).
// STRUCTURE
// - Shared package res_pkg:
//   - localparam LANE_W = 8;
//   - typedef enum {IDLE, PASS, ADD} res_state_e;
//   - typedef struct packed {data, keep, last} axis_beat_t (sized from AXI_DATA_WIDTH);
//   - function sat_add_i8.
// - Sub-module axis_skid_buf: 2-entry registered FIFO with valid/ready on both sides,
//   parameterised on beat width.
// - Top level: FSM, join logic, lane-generate saturating adders.
// TESTING
// - cfg_res_en=0; 4-beat frame, ps lanes=0x05, ready=1:
//   -> out lanes 0x05, 1 beat/cycle, rd2res_tready stays 0.
// - cfg_res_en=1; ps=0x70, rd=0x20 -> 0x7F. ps=0x80, rd=0xF0 -> 0x80. ps=0x03, rd=0xFE -> 0x01.
// - ADD mode, rd2res_tvalid low for 3 cycles:
//   -> ps2res_tready=0 for those cycles, no output beats, no data lost.
// - Downstream tready toggled randomly, 100-beat frame:
//   -> output order and data match the model; output held stable while stalled.
// - cfg_res_en flipped mid-frame:
//   -> mode unchanged until tlast; new value takes effect on the next frame's first beat.
// - rd tlast on beat 2 while ps tlast is on beat 3:
//   -> err_last_mismatch=1 and stays 1. Then rst_n=0 for one clk mid-frame
//      -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/res_add_unit_pkg.sv
// Shared types and helpers for the residual-add stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: lane width, FSM state encoding, default-width beat struct, int8 saturating add.
`ifndef DFLT_CORE_AXI_DATA_WIDTH
`define DFLT_CORE_AXI_DATA_WIDTH 64
`endif

package res_pkg;

  localparam int LANE_W = 8;
  localparam int DFLT_W = `DFLT_CORE_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    ADD  = 2'd2
  } res_state_e;

  // Beat layout at the default stream width; the top re-derives the same
  // layout from its own parameter so non-default widths stay consistent.
  typedef struct packed {
    logic [DFLT_W-1:0]        data;
    logic [DFLT_W/LANE_W-1:0] keep;
    logic                     last;
  } axis_beat_t;

  // Signed int8 + int8 with clamping to [-128, 127]. A 9-bit sum can never
  // wrap, so the comparison against the int8 limits is exact.
  function automatic logic [LANE_W-1:0] sat_add_i8(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
    logic signed [LANE_W:0] sum;
    sum = $signed({a[LANE_W-1], a}) + $signed({b[LANE_W-1], b});
    if (sum > 9'sd127) begin
      return 8'h7F;
    end else if (sum < -9'sd128) begin
      return 8'h80;
    end else begin
      return sum[LANE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/res_add_unit_skid.sv
// Two-entry registered FIFO used as the output skid buffer of the residual-add stage.
// Latency: a beat pushed in cycle N is visible on pop_* in cycle N+1.
// Backpressure: push_ready is registered (count < 2 next cycle); pop only when pop_ready.
// Ports: clk, rst_n (sync, active-low); push_valid/push_ready/push_data (write side);
//        pop_valid/pop_ready/pop_data (read side). BEAT_W sets the entry width.
module axis_skid_buf #(
  parameter int BEAT_W = 73
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [BEAT_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [BEAT_W-1:0] pop_data
);

  logic [BEAT_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              space;
  logic              push;
  logic              pop;

  assign push = push_valid & space;
  assign pop  = pop_ready & (count != 2'd0);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (!push && pop) begin
      count_next = count - 2'd1;
    end
  end

  // space is registered so push_ready carries no path from pop_ready.
  // It also stays low through reset, keeping every upstream ready at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      space  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
      space <= (count_next != 2'd2);
    end
  end

  assign push_ready = space;
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = mem[rd_ptr];

endmodule

// File: rtl/res_add_unit.sv
// Residual-add stage: joins partial sums with residuals, saturating int8 add or pass-through.
// Latency: one cycle from input handshake to output valid (through a 2-entry skid buffer).
// Backpressure: inputs are accepted only with buffer space; in ADD mode both streams move together.
// Ports: clk, rst_n (sync, active-low); cfg_res_en (sampled at frame start);
//        s_axis_ps2res_* partial sums in; s_axis_rd2res_* residuals in;
//        m_axis_res2ac_* results out; err_last_mismatch (sticky); frame_active.
module res_add_unit
  import res_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = `DFLT_CORE_AXI_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_res_en,
  output logic                        s_axis_ps2res_tready,
  input  logic                        s_axis_ps2res_tvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axis_ps2res_tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axis_ps2res_tkeep,
  input  logic                        s_axis_ps2res_tlast,
  output logic                        s_axis_rd2res_tready,
  input  logic                        s_axis_rd2res_tvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axis_rd2res_tdata,
  input  logic                        s_axis_rd2res_tlast,
  input  logic                        m_axis_res2ac_tready,
  output logic                        m_axis_res2ac_tvalid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axis_res2ac_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axis_res2ac_tkeep,
  output logic                        m_axis_res2ac_tlast,
  output logic                        err_last_mismatch,
  output logic                        frame_active
);

  localparam int LANES = AXI_DATA_WIDTH / LANE_W;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [LANES-1:0]          keep;
    logic                      last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  res_state_e                state;
  res_state_e                state_next;
  logic                      mode;
  logic                      space;
  logic                      fire;
  logic [AXI_DATA_WIDTH-1:0] res_data;
  beat_t                     in_beat;
  beat_t                     out_beat;
  logic [BEAT_W-1:0]         pop_bits;

  // In IDLE the next beat opens a frame, so the live config decides; inside
  // a frame the mode is frozen in the state so mid-frame config edits are ignored.
  assign mode = (state == IDLE) ? cfg_res_en : (state == ADD);

  assign s_axis_ps2res_tready = space & (~mode | s_axis_rd2res_tvalid);
  assign s_axis_rd2res_tready = space & mode & s_axis_ps2res_tvalid;
  assign fire                 = s_axis_ps2res_tvalid & s_axis_ps2res_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (fire) begin
      if (s_axis_ps2res_tlast) begin
        state_next = IDLE;
      end else if (mode) begin
        state_next = ADD;
      end else begin
        state_next = PASS;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] ps_lane;
    logic [LANE_W-1:0] rd_lane;
    assign ps_lane = s_axis_ps2res_tdata[i*LANE_W +: LANE_W];
    assign rd_lane = s_axis_rd2res_tdata[i*LANE_W +: LANE_W];
    assign res_data[i*LANE_W +: LANE_W] =
        !s_axis_ps2res_tkeep[i] ? '0 :
        mode                    ? sat_add_i8(ps_lane, rd_lane) : ps_lane;
  end

  always_comb begin
    in_beat      = '0;
    in_beat.data = res_data;
    in_beat.keep = s_axis_ps2res_tkeep;
    in_beat.last = s_axis_ps2res_tlast;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_last_mismatch <= 1'b0;
    end else if (fire && mode && (s_axis_ps2res_tlast != s_axis_rd2res_tlast)) begin
      err_last_mismatch <= 1'b1;
    end
  end

  axis_skid_buf #(
    .BEAT_W(BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(fire),
    .push_ready(space),
    .push_data (in_beat),
    .pop_valid (m_axis_res2ac_tvalid),
    .pop_ready (m_axis_res2ac_tready),
    .pop_data  (pop_bits)
  );

  assign out_beat            = pop_bits;
  assign m_axis_res2ac_tdata = out_beat.data;
  assign m_axis_res2ac_tkeep = out_beat.keep;
  assign m_axis_res2ac_tlast = out_beat.last;
  assign frame_active        = (state != IDLE);

endmodule

// File: tb/tb_res_add_unit.sv
// Scoreboard bench for res_add_unit: randomized and directed frames checked against a lane model.
module tb_res_add_unit;

  localparam int W = 64;
  localparam int K = W / 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_res_en = 1'b0;
  logic         ps_tready;
  logic         ps_tvalid = 1'b0;
  logic [W-1:0] ps_tdata = '0;
  logic [K-1:0] ps_tkeep = '0;
  logic         ps_tlast = 1'b0;
  logic         rd_tready;
  logic         rd_tvalid = 1'b0;
  logic [W-1:0] rd_tdata = '0;
  logic         rd_tlast = 1'b0;
  logic         m_tready = 1'b0;
  logic         m_tvalid;
  logic [W-1:0] m_tdata;
  logic [K-1:0] m_tkeep;
  logic         m_tlast;
  logic         err_last_mismatch;
  logic         frame_active;

  always #5 clk = ~clk;

  res_add_unit #(.AXI_DATA_WIDTH(W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_res_en          (cfg_res_en),
    .s_axis_ps2res_tready(ps_tready),
    .s_axis_ps2res_tvalid(ps_tvalid),
    .s_axis_ps2res_tdata (ps_tdata),
    .s_axis_ps2res_tkeep (ps_tkeep),
    .s_axis_ps2res_tlast (ps_tlast),
    .s_axis_rd2res_tready(rd_tready),
    .s_axis_rd2res_tvalid(rd_tvalid),
    .s_axis_rd2res_tdata (rd_tdata),
    .s_axis_rd2res_tlast (rd_tlast),
    .m_axis_res2ac_tready(m_tready),
    .m_axis_res2ac_tvalid(m_tvalid),
    .m_axis_res2ac_tdata (m_tdata),
    .m_axis_res2ac_tkeep (m_tkeep),
    .m_axis_res2ac_tlast (m_tlast),
    .err_last_mismatch   (err_last_mismatch),
    .frame_active        (frame_active)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model state: frame membership, the mode frozen at frame start, sticky error.
  bit in_frame = 1'b0;
  bit cur_mode = 1'b0;
  bit err_exp  = 1'b0;

  // Downstream ready control and output timing bookkeeping.
  bit rnd_rdy = 1'b0;
  bit rdy_fix = 1'b1;
  int cyc = 0;
  int out_cnt = 0;
  int first_out = -1;
  int last_out = -1;

  task automatic check(input bit ok, input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  initial begin : monitor
    bit   held;
    exp_t hold_b;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check(m_tvalid && m_tdata == hold_b.data && m_tkeep == hold_b.keep &&
                m_tlast == hold_b.last, "stall_stable", m_tdata, hold_b.data);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_beat", m_tdata, '0);
          end else begin
            e = exp_q.pop_front();
            check(m_tdata == e.data, "out_data", m_tdata, e.data);
            check(m_tkeep == e.keep && m_tlast == e.last, "out_keep_last",
                  {m_tkeep, m_tlast}, {e.keep, e.last});
          end
          out_cnt++;
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
        end
        held = m_tvalid && !m_tready;
        hold_b.data = m_tdata;
        hold_b.keep = m_tkeep;
        hold_b.last = m_tlast;
      end
    end
  end

  // Drive one ps beat (and its paired residual); rd_tvalid is held low for 'gap' cycles.
  task automatic send_beat(input logic [W-1:0] pd, input logic [K-1:0] kp, input logic lst,
                           input logic [W-1:0] rdd, input logic rlst, input int gap);
    int   waited;
    int   cyc_in;
    bit   done;
    bit   m;
    exp_t e;
    waited = 0;
    cyc_in = 0;
    done = 1'b0;
    ps_tdata = pd;
    ps_tkeep = kp;
    ps_tlast = lst;
    rd_tdata = rdd;
    rd_tlast = rlst;
    ps_tvalid = 1'b1;
    rd_tvalid = (gap == 0);
    while (!done) begin
      @(negedge clk);
      m = in_frame ? cur_mode : cfg_res_en;
      if (m && !rd_tvalid)
        check(!ps_tready, "ps_tready_while_rd_idle", W'(ps_tready), '0);
      if (ps_tready) begin
        cur_mode = m;
        for (int i = 0; i < K; i++) begin
          if (!kp[i]) e.data[i*8 +: 8] = 8'h00;
          else if (m) e.data[i*8 +: 8] = sat8(pd[i*8 +: 8], rdd[i*8 +: 8]);
          else e.data[i*8 +: 8] = pd[i*8 +: 8];
        end
        e.keep = kp;
        e.last = lst;
        exp_q.push_back(e);
        check(rd_tready == m, "rd_tready_on_fire", W'(rd_tready), W'(m));
        if (m && (rlst != lst)) err_exp = 1'b1;
        in_frame = !lst;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc_in++;
      if (cyc_in >= gap) rd_tvalid = 1'b1;
      waited++;
      if (!done && waited > 300) begin
        check(1'b0, "accept_timeout", W'(waited), '0);
        done = 1'b1;
      end
    end
    ps_tvalid = 1'b0;
    rd_tvalid = 1'b0;
    check(frame_active == in_frame, "frame_active", W'(frame_active), W'(in_frame));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "drain", W'(exp_q.size()), '0);
  endtask

  task automatic check_all_zero(input string tag);
    check(!ps_tready && !rd_tready && !m_tvalid, {tag, "_ready_valid"},
          W'({ps_tready, rd_tready, m_tvalid}), '0);
    check(m_tdata == '0 && m_tkeep == '0 && !m_tlast, {tag, "_out_beat"}, m_tdata, '0);
    check(!err_last_mismatch && !frame_active, {tag, "_err_active"},
          W'({err_last_mismatch, frame_active}), '0);
  endtask

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {K{b}};
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [W-1:0] pd;
    logic [W-1:0] rdd;
    logic [K-1:0] kp;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through frame, downstream always ready: 1 beat/cycle, rd never consumed.
    cfg_res_en = 1'b0;
    out_cnt = 0;
    first_out = -1;
    for (int b = 0; b < 4; b++) send_beat(rep(8'h05), '1, b == 3, rep(8'h33), b == 3, 0);
    wait_drain();
    check(out_cnt == 4, "pass_count", W'(out_cnt), W'(4));
    check(last_out - first_out == 3, "pass_throughput", W'(last_out - first_out), W'(3));

    // Add frame: positive clamp, negative clamp, plain wrap-free add, partial keep.
    cfg_res_en = 1'b1;
    send_beat(rep(8'h70), '1, 1'b0, rep(8'h20), 1'b0, 0);
    send_beat(rep(8'h80), '1, 1'b0, rep(8'hF0), 1'b0, 0);
    send_beat(rep(8'h03), '1, 1'b0, rep(8'hFE), 1'b0, 0);
    send_beat(rep(8'h11), 8'hA5, 1'b1, rep(8'h22), 1'b1, 0);
    wait_drain();

    // Residual stream idle for 3 cycles mid-frame.
    send_beat(rep(8'h01), '1, 1'b0, rep(8'h02), 1'b0, 0);
    send_beat(rep(8'h40), '1, 1'b0, rep(8'h50), 1'b0, 3);
    send_beat(rep(8'hC0), '1, 1'b1, rep(8'hB0), 1'b1, 0);
    wait_drain();

    // 100-beat random frame with random downstream stalls and residual gaps.
    rnd_rdy = 1'b1;
    for (int b = 0; b < 100; b++) begin
      pd  = {$urandom, $urandom};
      rdd = {$urandom, $urandom};
      kp  = K'($urandom);
      send_beat(pd, kp, b == 99, rdd, b == 99, $urandom_range(0, 2));
    end
    rnd_rdy = 1'b0;
    wait_drain();

    // Config flipped mid-frame: mode holds until tlast, new value applies next frame.
    cfg_res_en = 1'b1;
    send_beat(rep(8'h10), '1, 1'b0, rep(8'h01), 1'b0, 0);
    cfg_res_en = 1'b0;
    for (int b = 1; b < 4; b++) send_beat(rep(8'h10), '1, b == 3, rep(8'h01), b == 3, 0);
    for (int b = 0; b < 2; b++) send_beat(rep(8'h10), '1, b == 1, rep(8'h01), b == 1, 0);
    wait_drain();

    // tlast disagreement in ADD mode: residual ends on beat 2, partial sums on beat 3.
    cfg_res_en = 1'b1;
    check(!err_last_mismatch, "err_before", W'(err_last_mismatch), '0);
    for (int b = 0; b < 3; b++) send_beat(rep(8'h07), '1, b == 2, rep(8'h08), b == 1, 0);
    wait_drain();
    check(err_last_mismatch == err_exp, "err_set", W'(err_last_mismatch), W'(err_exp));
    for (int b = 0; b < 2; b++) send_beat(rep(8'h09), '1, b == 1, rep(8'h01), b == 1, 0);
    wait_drain();
    check(err_last_mismatch == err_exp, "err_sticky", W'(err_last_mismatch), W'(err_exp));

    // Reset in the middle of a frame with two beats parked in the buffer.
    rdy_fix = 1'b0;
    @(posedge clk);
    #1;
    send_beat(rep(8'h21), '1, 1'b0, rep(8'h01), 1'b0, 0);
    send_beat(rep(8'h22), '1, 1'b0, rep(8'h01), 1'b0, 0);
    check(m_tvalid, "buffered_before_reset", W'(m_tvalid), W'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midframe_reset");
    exp_q.delete();
    in_frame = 1'b0;
    err_exp = 1'b0;
    rst_n = 1'b1;
    rdy_fix = 1'b1;

    // Recovery frame after reset.
    cfg_res_en = 1'b0;
    for (int b = 0; b < 2; b++) send_beat(rep(8'h5A), '1, b == 1, rep(8'h01), b == 1, 0);
    wait_drain();
    check(!err_last_mismatch, "err_after_reset", W'(err_last_mismatch), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
